vga_timing_ctrl: RTL

//  Raster timing generator and output stage for the 640x480@60 VGA display path.

---
 rtl/vga_timing_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/vga_timing_ctrl.sv
// Raster timing generator and RGB output stage for a 640x480@60 VGA path.
// Drives pos_x/pos_y to pixel stages and aligns sync/blank with the returned pixel.
module vga_timing_ctrl #(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int PIX_LAT  = 1
) (
   input  logic        vga_clk,
   input  logic        rst,
   input  logic [23:0] pix_data,
   output logic [9:0]  pos_x,
   output logic [9:0]  pos_y,
   output logic        frame_start,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
   localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BACK);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BACK);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);

   logic [HW-1:0]      h_cnt;
   logic [VW-1:0]      v_cnt;
   logic               raw_hs;
   logic               raw_vs;
   logic               raw_act;
   logic [PIX_LAT-1:0] hs_dly;
   logic [PIX_LAT-1:0] vs_dly;
   logic [PIX_LAT-1:0] act_dly;
   logic               unused_pix_bits;

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge value of its neighbours.
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_comb begin
      raw_hs  = (h_cnt >= H_SYNC_END);
      raw_vs  = (v_cnt >= V_SYNC_END);
      raw_act = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
                (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
      pos_x   = 10'h3FF;
      pos_y   = 10'h3FF;
      if (raw_act) begin
         pos_x = 10'(h_cnt - H_ACT_BEG);
         pos_y = 10'(v_cnt - V_ACT_BEG);
      end
      frame_start = !rst && (h_cnt == '0) && (v_cnt == '0);
   end

   // The delay line matches the pixel-stage latency so sync, blank and colour
   // leave together; reset flushes it to blank so no stale pixel escapes.
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         hs_dly  <= '1;
         vs_dly  <= '1;
         act_dly <= '0;
      end else begin
         hs_dly[0]  <= raw_hs;
         vs_dly[0]  <= raw_vs;
         act_dly[0] <= raw_act;
         for (int i = 1; i < PIX_LAT; i++) begin
            hs_dly[i]  <= hs_dly[i-1];
            vs_dly[i]  <= vs_dly[i-1];
            act_dly[i] <= act_dly[i-1];
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         rgb   <= 12'h000;
      end else begin
         hsync <= hs_dly[PIX_LAT-1];
         vsync <= vs_dly[PIX_LAT-1];
         rgb   <= act_dly[PIX_LAT-1] ?
                  {pix_data[23:20], pix_data[15:12], pix_data[7:4]} : 12'h000;
      end
   end

   // Low nibbles are dropped by the 4-bit DAC.
   assign unused_pix_bits = ^{pix_data[19:16], pix_data[11:8], pix_data[3:0]};

endmodule
